// File: rtl/irb_pkg.sv
// Shared types and sizing constants for the PW kernel buffer path.
package irb_pkg;

   typedef enum logic [1:0] {EMPTY, FILL, FULL} kpw_bank_st_t;

   localparam int KPW_N_ELEM = 16;
   localparam int WG_W       = 8;
   localparam int Npar       = 4;

endpackage

// File: rtl/kpw_bank_ram.sv
// One kernel bank: single write port, registered read, array not reset.
module kpw_bank_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/kpw_pingpong_buf.sv
// Ping-pong kernel tile buffer: loader fills one bank while the PW array reads the other.
// Optional sticky protocol-error output `err` when KPW_PP_STATUS_EN is defined.
module kpw_pingpong_buf
   import irb_pkg::*;
#(
   parameter int DATA_W = WG_W + $clog2(Npar+1),
   parameter int DEPTH  = KPW_N_ELEM,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int LEN_W  = $clog2(DEPTH+1)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              rd_avail,
   output logic [LEN_W-1:0]  rd_len,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_vld,
   input  logic              rd_release
`ifdef KPW_PP_STATUS_EN
   ,output logic             err
`endif
);

   kpw_bank_st_t            st [2];
   logic [LEN_W-1:0]        len [2];
   logic                    wbank, rbank, rbank_q, oob_q;
   logic [ADDR_W-1:0]       wcnt;
   logic [1:0][DATA_W-1:0]  ram_q;

   logic wr_acc, wr_full, wr_close, rd_fire, rd_oob, rel;

   assign wr_ready = (st[wbank] != FULL);
   assign wr_acc   = wr_valid && wr_ready;
   assign wr_full  = (wcnt == ADDR_W'(DEPTH-1));
   assign wr_close = wr_acc && (wr_last || wr_full);

   assign rd_avail = (st[rbank] == FULL);
   assign rd_len   = rd_avail ? len[rbank] : '0;
   assign rd_fire  = rd_en && rd_avail;
   assign rd_oob   = (LEN_W'(rd_addr) >= rd_len);
   assign rel      = rd_release && rd_avail;

   // Close targets a non-FULL bank and release a FULL one, so they never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st[0]   <= EMPTY;
         st[1]   <= EMPTY;
         len[0]  <= '0;
         len[1]  <= '0;
         wbank   <= 1'b0;
         rbank   <= 1'b0;
         wcnt    <= '0;
         rd_vld  <= 1'b0;
         oob_q   <= 1'b0;
         rbank_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            if (wr_close) begin
               st[wbank]  <= FULL;
               len[wbank] <= LEN_W'(wcnt) + LEN_W'(1);
               wcnt       <= '0;
               wbank      <= ~wbank;
            end else begin
               st[wbank]  <= FILL;
               wcnt       <= wcnt + ADDR_W'(1);
            end
         end
         if (rel) begin
            st[rbank] <= EMPTY;
            rbank     <= ~rbank;
         end
         rd_vld <= rd_fire;
         if (rd_fire) begin
            oob_q   <= rd_oob;
            rbank_q <= rbank;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      kpw_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
         .clk   (clk),
         .we    (wr_acc && (wbank == 1'(b))),
         .waddr (wcnt),
         .wdata (wr_data),
         .re    (rd_fire && (rbank == 1'(b))),
         .raddr (rd_addr),
         .rdata (ram_q[b])
      );
   end

   // RAM output is unreset; gating by rd_vld keeps rd_data at 0 in reset and when idle.
   assign rd_data = (rd_vld && !oob_q) ? ram_q[rbank_q] : '0;

`ifdef KPW_PP_STATUS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if ((wr_valid && !wr_ready) || (rd_en && !rd_avail) || (rd_fire && rd_oob) ||
               (rd_release && !rd_avail) || (wr_acc && wr_full && !wr_last))
         err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_kpw_pingpong_buf.sv
// Randomized bench for kpw_pingpong_buf against a tile-queue model of the buffer.
module tb_kpw_pingpong_buf;
   import irb_pkg::*;

   localparam int DATA_W = WG_W + $clog2(Npar+1);
   localparam int DEPTH  = KPW_N_ELEM;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LEN_W  = $clog2(DEPTH+1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              wr_valid, wr_last, rd_en, rd_release;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr;
   logic              wr_ready, rd_avail, rd_vld;
   logic [LEN_W-1:0]  rd_len;
   logic [DATA_W-1:0] rd_data;
`ifdef KPW_PP_STATUS_EN
   logic              err;
`endif

   kpw_pingpong_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .wr_last    (wr_last),
      .rd_avail   (rd_avail),
      .rd_len     (rd_len),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_vld     (rd_vld),
      .rd_release (rd_release)
`ifdef KPW_PP_STATUS_EN
      ,.err       (err)
`endif
   );

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // Model: completed tiles as a word queue plus a length queue; head tile is the read tile.
   logic [DATA_W-1:0] fq[$];
   logic [DATA_W-1:0] cq[$];
   int                lq[$];
   logic              e_vld, e_err;
   logic [DATA_W-1:0] e_data;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      fq.delete();
      cq.delete();
      lq.delete();
      e_vld  = 1'b0;
      e_data = '0;
      e_err  = 1'b0;
   endfunction

   function automatic void model_step();
      bit ready, avail;
      int hl;
      ready  = (lq.size() < 2);
      avail  = (lq.size() > 0);
      hl     = avail ? lq[0] : 0;
      e_vld  = rd_en && avail;
      e_data = (e_vld && (int'(rd_addr) < hl)) ? fq[rd_addr] : '0;
      if (wr_valid && !ready) e_err = 1'b1;
      if (rd_en && !avail) e_err = 1'b1;
      if (e_vld && (int'(rd_addr) >= hl)) e_err = 1'b1;
      if (rd_release && !avail) e_err = 1'b1;
      if (wr_valid && ready) begin
         cq.push_back(wr_data);
         if (wr_last || cq.size() == DEPTH) begin
            if (!wr_last) e_err = 1'b1;
            lq.push_back(cq.size());
            foreach (cq[i]) fq.push_back(cq[i]);
            cq.delete();
         end
      end
      if (rd_release && avail) begin
         repeat (hl) void'(fq.pop_front());
         void'(lq.pop_front());
      end
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         cmp("wr_ready", 32'(wr_ready), 32'(lq.size() < 2));
         cmp("rd_avail", 32'(rd_avail), 32'(lq.size() > 0));
         cmp("rd_len",   32'(rd_len),   (lq.size() > 0) ? lq[0] : 0);
         cmp("rd_vld",   32'(rd_vld),   32'(e_vld));
         cmp("rd_data",  32'(rd_data),  32'(e_data));
`ifdef KPW_PP_STATUS_EN
         cmp("err",      32'(err),      32'(e_err));
`endif
      end
   end

   task automatic step(input bit wv, input logic [DATA_W-1:0] wd, input bit wl,
                       input bit re, input logic [ADDR_W-1:0] ra, input bit rr);
      wr_valid = wv; wr_data = wd; wr_last = wl;
      rd_en = re; rd_addr = ra; rd_release = rr;
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, '0, 0, 0, '0, 0);
   endtask

   task automatic write_tile(input int base, input int n, input bit last);
      for (int i = 0; i < n; i++)
         step(1, DATA_W'(base + i), last && (i == n-1), 0, '0, 0);
   endtask

   task automatic do_reset(input bit lit);
      rst_n = 1'b0;
      model_reset();
      #1;
      if (lit) begin
         cmp("rst_wr_ready", 32'(wr_ready), 32'd1);
         cmp("rst_rd_avail", 32'(rd_avail), 32'd0);
         cmp("rst_rd_len",   32'(rd_len),   32'd0);
         cmp("rst_rd_vld",   32'(rd_vld),   32'd0);
         cmp("rst_rd_data",  32'(rd_data),  32'd0);
      end
      wr_valid = 0; wr_last = 0; rd_en = 0; rd_release = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      wr_valid = 0; wr_data = '0; wr_last = 0;
      rd_en = 0; rd_addr = '0; rd_release = 0;
      model_reset();
      @(posedge clk);
      #1;
      cmp("init_wr_ready", 32'(wr_ready), 32'd1);
      cmp("init_rd_avail", 32'(rd_avail), 32'd0);
      cmp("init_rd_vld",   32'(rd_vld),   32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk_on = 1'b1;

      // Basic tile and read latency
      write_tile('h11, 4, 1);
      cmp("t1_rd_avail", 32'(rd_avail), 32'd1);
      cmp("t1_rd_len",   32'(rd_len),   32'd4);
      step(0, '0, 0, 1, ADDR_W'(2), 0);
      cmp("t1_rd_vld",   32'(rd_vld),   32'd1);
      cmp("t1_rd_data",  32'(rd_data),  32'h13);
      step(0, '0, 0, 0, '0, 1);
      idle(2);

      // Both banks full stalls the writer until release
      write_tile('h30, 3, 1);
      write_tile('h40, 5, 1);
      cmp("t2_wr_ready_full", 32'(wr_ready), 32'd0);
      step(0, '0, 0, 0, '0, 1);
      cmp("t2_rd_len",   32'(rd_len),   32'd5);
      cmp("t2_wr_ready", 32'(wr_ready), 32'd1);
      step(0, '0, 0, 0, '0, 1);
      idle(1);

      // Forced close at DEPTH
      write_tile('h50, DEPTH, 0);
      cmp("t3_rd_len", 32'(rd_len), 32'(DEPTH));
`ifdef KPW_PP_STATUS_EN
      cmp("t3_err", 32'(err), 32'd1);
`endif
      step(0, '0, 0, 0, '0, 1);
      idle(1);

      // Read and release together
      write_tile('h21, 4, 1);
      step(0, '0, 0, 1, '0, 1);
      cmp("t4_rd_data",  32'(rd_data),  32'h21);
      cmp("t4_rd_vld",   32'(rd_vld),   32'd1);
      cmp("t4_rd_avail", 32'(rd_avail), 32'd0);
      idle(1);

      // Out-of-tile read
      write_tile('h61, 4, 1);
      step(0, '0, 0, 1, ADDR_W'(6), 0);
      cmp("t5_rd_vld",  32'(rd_vld),  32'd1);
      cmp("t5_rd_data", 32'(rd_data), 32'd0);
`ifdef KPW_PP_STATUS_EN
      cmp("t5_err", 32'(err), 32'd1);
`endif
      step(0, '0, 0, 0, '0, 1);
      idle(1);

      // Reset mid-fill, then a fresh 1-beat tile
      write_tile('h71, 2, 0);
      do_reset(1);
      write_tile('h5A, 1, 1);
      cmp("t6_rd_len", 32'(rd_len), 32'd1);
      step(0, '0, 0, 1, '0, 1);
      cmp("t6_rd_data", 32'(rd_data), 32'h5A);
      idle(2);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 499) == 0)
            do_reset(0);
         else
            step($urandom_range(0, 9) < 7, DATA_W'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) < 6, ADDR_W'($urandom_range(0, DEPTH-1)),
                 $urandom_range(0, 15) == 0);
      end
      idle(2);
      chk_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
